// File: rtl/bayer_stream_ctrl_pkg.sv
// Shared definitions for the Bayer stream controller: beat type codes,
// the pixel mask, the control FSM state encoding and small decode helpers.
package bayer_stream_ctrl_pkg;

  // Beat type codes carried on dtypei
  localparam int DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'h4;
  // Any code with this bit set is a pixel beat (0x8..0xF)
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'h8;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_ROW   = 2'd2
  } state_e;

  // Classified beat, after dvi qualification
  typedef enum logic [2:0] {
    BEAT_NONE = 3'd0,
    BEAT_FS   = 3'd1,
    BEAT_FE   = 3'd2,
    BEAT_RS   = 3'd3,
    BEAT_RE   = 3'd4,
    BEAT_PIX  = 3'd5
  } beat_e;

  // Pixels take precedence over the marker codes; unknown codes map to NONE.
  function automatic beat_e decode_beat(input logic dv,
                                        input logic [DTYPE_WIDTH-1:0] dt);
    beat_e b;
    b = BEAT_NONE;
    if (dv) begin
      if ((dt & DTYPE_PIXEL_MASK) != '0) begin
        b = BEAT_PIX;
      end else begin
        case (dt)
          DTYPE_FRAME_START: b = BEAT_FS;
          DTYPE_FRAME_END:   b = BEAT_FE;
          DTYPE_ROW_START:   b = BEAT_RS;
          DTYPE_ROW_END:     b = BEAT_RE;
          default:           b = BEAT_NONE;
        endcase
      end
    end
    return b;
  endfunction

  // Phase seen by the interpolator after flips and odd crop offsets.
  function automatic logic [1:0] calc_phase(input logic [1:0] base,
                                            input logic mirror,
                                            input logic flip,
                                            input logic row_off0,
                                            input logic col_off0);
    return {base[1] ^ flip ^ row_off0, base[0] ^ mirror ^ col_off0};
  endfunction

endpackage

// File: rtl/bayer_stream_ctrl_watchdog.sv
// stream_watchdog: counts consecutive cycles without a stream beat while the
// controller is inside a frame, and flags expiry when the count reaches the
// programmed limit. A zero limit disables expiry.
module stream_watchdog #(
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     active_i,
  input  logic                     dvi_i,
  input  logic [TIMEOUT_WIDTH-1:0] limit_i,
  output logic                     expire_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  logic [TIMEOUT_WIDTH-1:0] count_q;
  logic [TIMEOUT_WIDTH-1:0] count_d;
  logic [TIMEOUT_WIDTH-1:0] count_inc;

  // Idle-cycle counter: cleared by any beat or outside a frame, saturates
  always_comb begin
    count_inc = count_q + CNT_ONE;
    count_d   = count_q;
    if (!active_i || dvi_i) begin
      count_d = '0;
    end else if (!(&count_q)) begin
      count_d = count_inc;
    end
  end

  // Expire on the idle cycle that brings the count up to the limit
  always_comb begin
    expire_o = active_i && !dvi_i && (limit_i != '0) && (count_inc == limit_i);
  end

  // Counter register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bayer_stream_ctrl.sv
// bayer_stream_ctrl: tracks frame/row structure of a Bayer pixel stream,
// supplies a frame-stable Bayer phase to the interpolator, measures frame
// geometry and raises sticky protocol errors.
// Optional build macro INTERP_CTRL_WATCHDOG_EN adds an idle-stream watchdog
// (stream_watchdog) that aborts a stalled frame; without it err_timeout is 0.
module bayer_stream_ctrl
  import bayer_stream_ctrl_pkg::*;
#(
  parameter int NUM_COLS_WIDTH = 11,
  parameter int NUM_ROWS_WIDTH = 11,
  parameter int TIMEOUT_WIDTH  = 24
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      dvi,
  input  logic [DTYPE_WIDTH-1:0]    dtypei,
  input  logic [1:0]                cfg_base_phase,
  input  logic                      cfg_mirror,
  input  logic                      cfg_flip,
  input  logic                      cfg_col_off0,
  input  logic                      cfg_row_off0,
  input  logic                      cfg_update,
  input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout,
  input  logic                      err_clr,
  output logic [1:0]                phase,
  output logic                      in_frame,
  output logic [15:0]               frame_count,
  output logic [NUM_ROWS_WIDTH-1:0] num_rows,
  output logic [NUM_COLS_WIDTH-1:0] num_cols,
  output logic                      err_seq,
  output logic                      err_cols,
  output logic                      err_timeout
);

  localparam logic [NUM_COLS_WIDTH-1:0] COL_ONE = {{(NUM_COLS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_ONE = {{(NUM_ROWS_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [NUM_COLS_WIDTH-1:0] sat_inc_col(input logic [NUM_COLS_WIDTH-1:0] v);
    return (&v) ? v : v + COL_ONE;
  endfunction

  function automatic logic [NUM_ROWS_WIDTH-1:0] sat_inc_row(input logic [NUM_ROWS_WIDTH-1:0] v);
    return (&v) ? v : v + ROW_ONE;
  endfunction

  beat_e  beat;
  state_e state_q, state_d;
  logic   wd_expire;

  logic [1:0]                shadow_q, shadow_d;
  logic                      pending_q, pending_d;
  logic [1:0]                phase_q, phase_d;
  logic                      in_frame_q;
  logic [NUM_COLS_WIDTH-1:0] col_q, col_d;
  logic [NUM_COLS_WIDTH-1:0] ref_q, ref_d;
  logic [NUM_ROWS_WIDTH-1:0] row_q, row_d;
  logic [NUM_ROWS_WIDTH-1:0] nrows_q, nrows_d;
  logic [NUM_COLS_WIDTH-1:0] ncols_q, ncols_d;
  logic [15:0]               fcount_q, fcount_d;
  logic                      err_seq_q, err_seq_d;
  logic                      err_cols_q, err_cols_d;
  logic                      err_tmo_q, err_tmo_d;
  logic                      seq_set, cols_set;

  assign beat = decode_beat(dvi, dtypei);

`ifdef INTERP_CTRL_WATCHDOG_EN
  stream_watchdog #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .resetb   (resetb),
    .active_i (state_q != ST_IDLE),
    .dvi_i    (dvi),
    .limit_i  (cfg_timeout),
    .expire_o (wd_expire)
  );
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign wd_expire = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only beats move the FSM, except a watchdog abort
  always_comb begin
    state_d = state_q;
    if (wd_expire) begin
      state_d = ST_IDLE;
    end else begin
      case (beat)
        BEAT_FS: state_d = ST_FRAME;
        BEAT_RS: if (state_q == ST_FRAME) state_d = ST_ROW;
        BEAT_RE: if (state_q == ST_ROW)   state_d = ST_FRAME;
        BEAT_FE: if (state_q == ST_FRAME) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: counter, geometry and error updates for the current beat
  always_comb begin
    col_d    = col_q;
    ref_d    = ref_q;
    row_d    = row_q;
    nrows_d  = nrows_q;
    ncols_d  = ncols_q;
    fcount_d = fcount_q;
    seq_set  = 1'b0;
    cols_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Anything but FRAME_START is treated as mid-frame debris and dropped
        if (beat == BEAT_FS) begin
          row_d = '0;
          col_d = '0;
          ref_d = '0;
        end
      end
      ST_FRAME: begin
        case (beat)
          BEAT_FS: begin
            seq_set = 1'b1;
            row_d   = '0;
            col_d   = '0;
            ref_d   = '0;
          end
          BEAT_RS: col_d = '0;
          BEAT_FE: begin
            nrows_d  = row_q;
            ncols_d  = ref_q;
            fcount_d = fcount_q + 16'd1;
          end
          BEAT_RE, BEAT_PIX: seq_set = 1'b1;
          default: ;
        endcase
      end
      ST_ROW: begin
        case (beat)
          BEAT_FS: begin
            seq_set = 1'b1;
            row_d   = '0;
            col_d   = '0;
            ref_d   = '0;
          end
          BEAT_PIX: col_d = sat_inc_col(col_q);
          BEAT_RE: begin
            row_d = sat_inc_row(row_q);
            // First row of the frame defines the expected width
            if (row_q == '0) begin
              ref_d = col_q;
            end else if (col_q != ref_q) begin
              cols_set = 1'b1;
            end
          end
          BEAT_RS, BEAT_FE: seq_set = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Phase shadow: a new update always wins over applying the old one
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    phase_d   = phase_q;
    if (cfg_update) begin
      shadow_d  = calc_phase(cfg_base_phase, cfg_mirror, cfg_flip,
                             cfg_row_off0, cfg_col_off0);
      pending_d = 1'b1;
    end else if ((beat == BEAT_FS) && pending_q) begin
      phase_d   = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Sticky errors: a set in the same cycle as err_clr is kept
  always_comb begin
    err_seq_d  = seq_set  | (err_seq_q  & ~err_clr);
    err_cols_d = cols_set | (err_cols_q & ~err_clr);
`ifdef INTERP_CTRL_WATCHDOG_EN
    err_tmo_d  = wd_expire | (err_tmo_q & ~err_clr);
`else
    err_tmo_d  = 1'b0;
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      phase_q    <= '0;
      in_frame_q <= 1'b0;
      col_q      <= '0;
      ref_q      <= '0;
      row_q      <= '0;
      nrows_q    <= '0;
      ncols_q    <= '0;
      fcount_q   <= '0;
      err_seq_q  <= 1'b0;
      err_cols_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      phase_q    <= phase_d;
      in_frame_q <= (state_d != ST_IDLE);
      col_q      <= col_d;
      ref_q      <= ref_d;
      row_q      <= row_d;
      nrows_q    <= nrows_d;
      ncols_q    <= ncols_d;
      fcount_q   <= fcount_d;
      err_seq_q  <= err_seq_d;
      err_cols_q <= err_cols_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign phase       = phase_q;
  assign in_frame    = in_frame_q;
  assign frame_count = fcount_q;
  assign num_rows    = nrows_q;
  assign num_cols    = ncols_q;
  assign err_seq     = err_seq_q;
  assign err_cols    = err_cols_q;
  assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_bayer_stream_ctrl.sv
// Directed testbench for bayer_stream_ctrl: a vector table for a plain 4x3
// frame plus hand-written sequences for phase update, column mismatch,
// sequence errors, saturation, mid-frame reset and (optionally) the watchdog.
module tb_bayer_stream_ctrl;
  import bayer_stream_ctrl_pkg::*;

  localparam logic [3:0] FS  = DTYPE_FRAME_START;
  localparam logic [3:0] FE  = DTYPE_FRAME_END;
  localparam logic [3:0] RS  = DTYPE_ROW_START;
  localparam logic [3:0] RE  = DTYPE_ROW_END;
  localparam logic [3:0] PX  = 4'h8;

  logic        clk;
  logic        resetb;
  logic        dvi;
  logic [3:0]  dtypei;
  logic [1:0]  cfg_base_phase;
  logic        cfg_mirror, cfg_flip, cfg_col_off0, cfg_row_off0, cfg_update;
  logic [23:0] cfg_timeout;
  logic        err_clr;
  logic [1:0]  phase;
  logic        in_frame;
  logic [15:0] frame_count;
  logic [10:0] num_rows;
  logic [10:0] num_cols;
  logic        err_seq, err_cols, err_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dv;
    logic [3:0]  dt;
    logic        inf;
    logic [15:0] fc;
    logic [10:0] nr;
    logic [10:0] nc;
  } vec_t;

  vec_t vecs[$];

  bayer_stream_ctrl dut (
    .clk            (clk),
    .resetb         (resetb),
    .dvi            (dvi),
    .dtypei         (dtypei),
    .cfg_base_phase (cfg_base_phase),
    .cfg_mirror     (cfg_mirror),
    .cfg_flip       (cfg_flip),
    .cfg_col_off0   (cfg_col_off0),
    .cfg_row_off0   (cfg_row_off0),
    .cfg_update     (cfg_update),
    .cfg_timeout    (cfg_timeout),
    .err_clr        (err_clr),
    .phase          (phase),
    .in_frame       (in_frame),
    .frame_count    (frame_count),
    .num_rows       (num_rows),
    .num_cols       (num_cols),
    .err_seq        (err_seq),
    .err_cols       (err_cols),
    .err_timeout    (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] out_vec();
    return {20'd0, phase, in_frame, frame_count, num_rows, num_cols,
            err_seq, err_cols, err_timeout};
  endfunction

  function automatic logic [63:0] exp_vec(input logic [1:0] ph, input logic inf,
                                          input logic [15:0] fc, input logic [10:0] nr,
                                          input logic [10:0] nc, input logic es,
                                          input logic ec, input logic et);
    return {20'd0, ph, inf, fc, nr, nc, es, ec, et};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [3:0] dt, input logic inf,
                     input logic [15:0] fc, input logic [10:0] nr, input logic [10:0] nc);
    vec_t v;
    v.dv = dv; v.dt = dt; v.inf = inf; v.fc = fc; v.nr = nr; v.nc = nc;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [3:0] dt);
    dvi = 1'b1;
    dtypei = dt;
    @(negedge clk);
    dvi = 1'b0;
    dtypei = 4'h0;
  endtask

  task automatic send_row(input int n);
    send(RS);
    for (int i = 0; i < n; i++) send(PX);
    send(RE);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    dvi = 1'b0; dtypei = 4'h0; cfg_base_phase = 2'b00; cfg_mirror = 1'b0;
    cfg_flip = 1'b0; cfg_col_off0 = 1'b0; cfg_row_off0 = 1'b0; cfg_update = 1'b0;
    cfg_timeout = 24'd0; err_clr = 1'b0;
    resetb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("reset_state", out_vec(), 64'd0);

    // Table: one 4x3 frame with ignored beats sprinkled in
    add(1'b1, FS, 1'b1, 16'd0, 11'd0, 11'd0);
    for (int r = 0; r < 3; r++) begin
      add(1'b1, RS,    1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b1, 4'h8,  1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b1, 4'h9,  1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b1, 4'h5,  1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b1, 4'hC,  1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b0, 4'h8,  1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b1, 4'hF,  1'b1, 16'd0, 11'd0, 11'd0);
      add(1'b1, RE,    1'b1, 16'd0, 11'd0, 11'd0);
    end
    add(1'b1, FE,   1'b0, 16'd1, 11'd3, 11'd4);
    add(1'b1, 4'h0, 1'b0, 16'd1, 11'd3, 11'd4);
    add(1'b1, PX,   1'b0, 16'd1, 11'd3, 11'd4);
    add(1'b1, RE,   1'b0, 16'd1, 11'd3, 11'd4);
    add(1'b0, FS,   1'b0, 16'd1, 11'd3, 11'd4);

    foreach (vecs[i]) begin
      dvi = vecs[i].dv;
      dtypei = vecs[i].dt;
      @(negedge clk);
      check($sformatf("table_%0d", i), out_vec(),
            exp_vec(2'b00, vecs[i].inf, vecs[i].fc, vecs[i].nr, vecs[i].nc, 1'b0, 1'b0, 1'b0));
    end
    dvi = 1'b0;
    dtypei = 4'h0;

    // Phase update deferred to the frame after the request
    do_reset();
    cfg_mirror = 1'b1;
    send(FS);
    check("phase_no_pending", {62'd0, phase}, 64'd0);
    send(RS);
    send(PX);
    cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    check("phase_mid_frame", {62'd0, phase}, 64'd0);
    send(PX);
    send(RE);
    send(FE);
    check("phase_after_fe", {62'd0, phase}, 64'd0);
    send(FS);
    check("phase_applied", {62'd0, phase}, 64'd1);
    send(FE);
    cfg_base_phase = 2'b10;
    cfg_mirror = 1'b0;
    dvi = 1'b1; dtypei = FS; cfg_update = 1'b1;
    @(negedge clk);
    dvi = 1'b0; dtypei = 4'h0; cfg_update = 1'b0;
    check("phase_conflict_hold", {62'd0, phase}, 64'd1);
    send(FE);
    send(FS);
    check("phase_conflict_next", {62'd0, phase}, 64'd2);
    send(FE);
    cfg_base_phase = 2'b00; cfg_row_off0 = 1'b1; cfg_col_off0 = 1'b1;
    cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    send(FS);
    check("phase_offsets", {62'd0, phase}, 64'd3);
    check("phase_no_err", {62'd0, err_seq, err_cols}, 64'd0);

    // Column mismatch, set-wins over clear, then clear
    do_reset();
    send(FS);
    send_row(4);
    send_row(4);
    check("cols_ok", {63'd0, err_cols}, 64'd0);
    send_row(3);
    check("cols_mismatch", {63'd0, err_cols}, 64'd1);
    send(RS);
    send(PX);
    send(PX);
    dvi = 1'b1; dtypei = RE; err_clr = 1'b1;
    @(negedge clk);
    dvi = 1'b0; dtypei = 4'h0; err_clr = 1'b0;
    check("cols_set_wins", {63'd0, err_cols}, 64'd1);
    send(FE);
    check("cols_geom", out_vec(), exp_vec(2'b00, 1'b0, 16'd1, 11'd4, 11'd4, 1'b0, 1'b1, 1'b0));
    pulse_clr();
    check("cols_cleared", {63'd0, err_cols}, 64'd0);

    // FRAME_START inside a row restarts the frame
    do_reset();
    send(FS);
    send(RS);
    send(PX);
    send(FS);
    check("fs_in_row", {62'd0, err_seq, in_frame}, 64'd3);
    pulse_clr();
    send(RS);
    check("restart_in_frame", {63'd0, err_seq}, 64'd0);
    send(PX);
    send(PX);
    send(RE);
    send(FE);
    check("restart_geom", out_vec(), exp_vec(2'b00, 1'b0, 16'd1, 11'd1, 11'd2, 1'b0, 1'b0, 1'b0));
    send(FS);
    send(PX);
    check("pix_in_frame", {62'd0, err_seq, in_frame}, 64'd3);
    pulse_clr();
    send(RS);
    send(FE);
    check("fe_in_row", {62'd0, err_seq, in_frame}, 64'd3);
    send(RE);
    send(FE);
    check("fe_after_row", {47'd0, in_frame, frame_count}, {47'd0, 1'b0, 16'd2});

    // Column counter saturation
    do_reset();
    send(FS);
    send_row(2050);
    send(FE);
    check("col_saturate", out_vec(), exp_vec(2'b00, 1'b0, 16'd1, 11'd1, 11'd2047, 1'b0, 1'b0, 1'b0));

    // Reset mid-row, then stray beats are dropped silently
    do_reset();
    send(FS);
    send(RS);
    send(PX);
    send(PX);
    #2 resetb = 1'b0;
    #1 check("reset_mid_row", out_vec(), 64'd0);
    @(negedge clk);
    resetb = 1'b1;
    send(RE);
    check("post_reset_re", out_vec(), 64'd0);
    send(PX);
    check("post_reset_px", out_vec(), 64'd0);
    send(PX);
    check("post_reset_px2", out_vec(), 64'd0);
    send(FS);
    send_row(1);
    send(FE);
    check("post_reset_frame", out_vec(), exp_vec(2'b00, 1'b0, 16'd1, 11'd1, 11'd1, 1'b0, 1'b0, 1'b0));

`ifdef INTERP_CTRL_WATCHDOG_EN
    // Stalled stream aborts the frame after the programmed idle cycles
    do_reset();
    cfg_timeout = 24'd10;
    send(FS);
    send_row(4);
    send(FE);
    send(FS);
    send(RS);
    send(PX);
    repeat (9) @(negedge clk);
    check("wd_before", {62'd0, err_timeout, in_frame}, 64'd1);
    @(negedge clk);
    check("wd_expired", out_vec(), exp_vec(2'b00, 1'b0, 16'd1, 11'd1, 11'd4, 1'b0, 1'b0, 1'b1));
`else
    check("timeout_tied", {63'd0, err_timeout}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bayer_stream_ctrl.md
BAYER_STREAM_CTRL -- requirements
Module: bayer_stream_ctrl

Interface
REQ-001 SHALL have parameter NUM_COLS_WIDTH, default 11, the width of the column counter.
REQ-002 SHALL have parameter NUM_ROWS_WIDTH, default 11, the width of the row counter.
REQ-003 SHALL have parameter TIMEOUT_WIDTH, default 24, the width of the watchdog counter.
REQ-004 SHALL have clk  input  1  clock.
REQ-005 SHALL have resetb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have dvi  input  1  stream beat valid (same stream that feeds the interpolator).
REQ-007 SHALL have dtypei  input  `DTYPE_WIDTH  beat type.
REQ-008 SHALL have cfg_base_phase  input  2  Bayer phase of the unflipped, uncropped sensor.
REQ-009 SHALL have cfg_mirror / cfg_flip  input  1 each  sensor column / row reversal.
REQ-010 SHALL have cfg_col_off0 / cfg_row_off0  input  1 each  LSB of the crop column / row offset.
REQ-011 SHALL have cfg_update  input  1  pulse that marks the configuration inputs as pending.
REQ-012 SHALL have cfg_timeout  input  TIMEOUT_WIDTH  watchdog limit in idle cycles.
REQ-013 SHALL have err_clr  input  1  pulse that clears the sticky errors.
REQ-014 SHALL have phase  output  2  registered phase for the interpolator.
REQ-015 SHALL have in_frame  output  1  high from FRAME_START through FRAME_END.
REQ-016 SHALL have frame_count  output  16  count of completed frames, wraps.
REQ-017 SHALL have num_rows / num_cols  output  NUM_ROWS_WIDTH / NUM_COLS_WIDTH  geometry of the last completed frame.
REQ-018 SHALL have err_seq, err_cols, err_timeout  output  1 each  sticky error flags.

Function
REQ-019 SHALL compute the next phase as {cfg_base_phase[1]^cfg_flip^cfg_row_off0, cfg_base_phase[0]^cfg_mirror^cfg_col_off0}.
REQ-020 SHALL capture that next phase into a shadow register on cfg_update.
REQ-021 SHALL copy the shadow register to phase on the cycle after a FRAME_START beat, and only when an update is pending; the pending flag then clears.
REQ-022 SHALL hold phase constant for the whole frame.
REQ-023 SHALL keep the update pending, with the new value captured, when cfg_update and FRAME_START arrive in the same cycle; the update applies at the next frame.
REQ-024 SHALL implement the states IDLE, FRAME (between rows) and ROW, with transitions evaluated only on dvi beats.
REQ-025 IDLE SHALL move to FRAME on FRAME_START and clear the row counter.
REQ-026 FRAME SHALL move to ROW on ROW_START and clear the column counter.
REQ-027 In ROW, a beat with dtypei & `DTYPE_PIXEL_MASK nonzero SHALL increment the column counter, saturating at its maximum.
REQ-028 ROW SHALL move to FRAME on ROW_END and increment the row counter, saturating at its maximum.
REQ-029 FRAME SHALL move to IDLE on FRAME_END, load num_rows and num_cols, and increment frame_count.
REQ-030 On ROW_END of row 0, the column count SHALL be latched as the reference.
REQ-031 On each later ROW_END, a column count different from the reference SHALL set err_cols.
REQ-032 A FRAME_START outside IDLE SHALL set err_seq and restart the frame, entering FRAME.
REQ-033 Any other beat that is illegal for the current state SHALL set err_seq and leave the state unchanged.
REQ-034 Other dtypes SHALL be ignored.
REQ-035 The error flags SHALL be sticky; err_clr clears them, and when set and clear occur in the same cycle, set wins.
REQ-036 in_frame SHALL be registered and be high whenever the state is not IDLE.
REQ-037 All outputs SHALL be registered, with 1-cycle latency from the causing beat.

Reset
REQ-038 Reset SHALL drive state IDLE and phase 0, with the shadow register 0 and no update pending.
REQ-039 Reset SHALL clear all counters, num_rows, num_cols, frame_count and all error flags, and drive in_frame 0.
REQ-040 Reset asserted mid-frame SHALL abandon the frame; the first beat accepted after reset that is not FRAME_START is ignored, with no error.

Configuration
REQ-041 With INTERP_CTRL_WATCHDOG_EN defined, a counter SHALL count cycles without dvi while the state is not IDLE.
REQ-042 With INTERP_CTRL_WATCHDOG_EN defined, the counter SHALL clear on any dvi.
REQ-043 With INTERP_CTRL_WATCHDOG_EN defined, when the counter reaches cfg_timeout (nonzero), the block SHALL set err_timeout and force IDLE without updating num_rows, num_cols or frame_count.
REQ-044 With INTERP_CTRL_WATCHDOG_EN undefined, the counter SHALL be absent, cfg_timeout ignored and err_timeout tied 0.

Structure
REQ-045 The dtype codes and `DTYPE_PIXEL_MASK SHALL come from the shared dtypes.v.
REQ-046 The state encodings SHALL be placed in a shared bayer_ctrl_defs.v header.
REQ-047 The watchdog SHALL be a sub-module named stream_watchdog.

Verification
REQ-048 Bench SHALL cover: 4x3-pixel frame (3 rows of 4 pixels) -> num_cols=4, num_rows=3, frame_count=1, no errors.
REQ-049 Bench SHALL cover: base=0 with mirror=1, cfg_update mid-frame -> phase stays 0 until the cycle after the next FRAME_START, then becomes 1.
REQ-050 Bench SHALL cover: row 2 has 3 pixels, rows 0 and 1 have 4 -> err_cols=1; err_clr with no further error -> 0.
REQ-051 Bench SHALL cover: FRAME_START received while in ROW -> err_seq=1, state FRAME, row counter 0.
REQ-052 Bench SHALL cover: watchdog build, cfg_timeout=10, dvi stops mid-row -> err_timeout=1 after 10 cycles, in_frame=0, frame_count unchanged.
REQ-053 Bench SHALL cover: resetb pulsed mid-row, then ROW_END and pixel beats -> all outputs 0, no errors until the next valid frame.
